game_dialog_ctrl: RTL and testbench

Parametrised dialog controller and text-box overlay for the VGA game pipeline, placed after the map/sprite stages and before the output register. It tracks which NPC the player stands on, steps through a multi-page dialog with edge-detected keys, reveals text character-by-character, and maintains one sticky quest flag per NPC with a chained prerequisite rule. Glyph rows come from the external font/text ROM pair; the box is drawn over the incoming rgb.

---
 rtl/game_dialog_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_game_dialog_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_dialog_ctrl.sv
// NPC dialog controller with a 128x64 text-box overlay on a 3-clock video pipeline.
// Define DIALOG_TYPEWRITER_EN to enable the per-character reveal (TYPE state).
module game_dialog_ctrl #(
    parameter int unsigned NUM_NPC       = 4,
    parameter int unsigned PAGES         = 4,
    parameter int unsigned BOX_X         = 400,
    parameter int unsigned BOX_Y         = 600,
    parameter int unsigned REVEAL_FRAMES = 2,
    parameter logic [11:0] TEXT_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR      = 12'hFF0,
    localparam int unsigned NPC_W        = (NUM_NPC > 1) ? $clog2(NUM_NPC) : 1,
    localparam int unsigned PAGE_W       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [10:0]        i_hcount,
    input  logic [10:0]        i_vcount,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_hblnk,
    input  logic               i_vblnk,
    input  logic [11:0]        i_rgb,
    output logic [10:0]        o_hcount,
    output logic [10:0]        o_vcount,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblnk,
    output logic               o_vblnk,
    output logic [11:0]        o_rgb,
    input  logic [3:0]         i_key,
    input  logic [3:0]         i_current_pix,
    output logic [7:0]         o_char_xy,
    output logic [3:0]         o_char_line,
    input  logic [7:0]         i_char_line_pixels,
    output logic [NPC_W-1:0]   o_npc_sel,
    output logic [PAGE_W-1:0]  o_page,
    output logic               o_active,
    output logic [NUM_NPC-1:0] o_flags
);

    localparam logic [10:0]       BX        = 11'(BOX_X);
    localparam logic [10:0]       BY        = 11'(BOX_Y);
    localparam logic [4:0]        NPC_HI    = 5'(NUM_NPC + 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    typedef enum logic [1:0] {StIdle, StType, StWait} state_e;

    state_e              r_state, w_state_d;
    logic [NPC_W-1:0]    r_npc, w_npc_d;
    logic [3:0]          r_pix, w_pix_d;
    logic [PAGE_W-1:0]   r_page, w_page_d;
    logic [NUM_NPC-1:0]  r_flags, w_flags_d;
    logic [3:0]          r_key, r_key_d;
    logic                w_key_ev, w_next_ev, w_accept_ev, w_npc_hit, w_prereq;

    // Key event only on the registered 0 -> non-zero transition, so held keys fire once.
    assign w_key_ev    = (r_key != 4'h0) && (r_key_d == 4'h0);
    assign w_next_ev   = w_key_ev && (r_key == 4'h2);
    assign w_accept_ev = w_key_ev && (r_key == 4'h1);
    assign w_npc_hit   = (i_current_pix >= 4'd2) && ({1'b0, i_current_pix} <= NPC_HI);
    assign w_prereq    = (r_npc == '0) || r_flags[r_npc - 1'b1];

`ifdef DIALOG_TYPEWRITER_EN
    localparam int unsigned      FRM_W    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(REVEAL_FRAMES - 1);

    logic [6:0]       r_reveal, w_reveal_d;
    logic [FRM_W-1:0] r_frm, w_frm_d;
    logic             r_vblnk;
    logic             w_tick;

    assign w_tick = i_vblnk && !r_vblnk;
`endif

    always_comb begin
        w_state_d = r_state;
        w_npc_d   = r_npc;
        w_pix_d   = r_pix;
        w_page_d  = r_page;
        w_flags_d = r_flags;
`ifdef DIALOG_TYPEWRITER_EN
        w_reveal_d = r_reveal;
        w_frm_d    = r_frm;
`endif
        case (r_state)
            StIdle: begin
                if (w_npc_hit) begin
                    w_npc_d  = NPC_W'(i_current_pix - 4'd2);
                    w_pix_d  = i_current_pix;
                    w_page_d = '0;
`ifdef DIALOG_TYPEWRITER_EN
                    w_reveal_d = '0;
                    w_frm_d    = '0;
                    w_state_d  = StType;
`else
                    w_state_d  = StWait;
`endif
                end
            end
`ifdef DIALOG_TYPEWRITER_EN
            StType: begin
                if (w_next_ev) begin
                    w_reveal_d = 7'd64;
                    w_state_d  = StWait;
                end else if (w_tick) begin
                    if (r_frm == FRM_LAST) begin
                        w_frm_d    = '0;
                        w_reveal_d = r_reveal + 7'd1;
                        if (r_reveal == 7'd63) w_state_d = StWait;
                    end else begin
                        w_frm_d = r_frm + 1'b1;
                    end
                end
            end
`endif
            StWait: begin
                if (w_next_ev) begin
                    if (r_page != PAGE_LAST) begin
                        w_page_d = r_page + 1'b1;
`ifdef DIALOG_TYPEWRITER_EN
                        w_reveal_d = '0;
                        w_frm_d    = '0;
                        w_state_d  = StType;
`endif
                    end else begin
                        w_state_d = StIdle;
                        w_page_d  = '0;
                    end
                end else if (w_accept_ev && (r_page == PAGE_LAST)) begin
                    if (w_prereq) w_flags_d[r_npc] = 1'b1;
                    w_state_d = StIdle;
                    w_page_d  = '0;
                end
            end
            default: w_state_d = StIdle;
        endcase
`ifdef DIALOG_TYPEWRITER_EN
        if (w_state_d == StIdle) w_reveal_d = '0;
`endif
        // Walking off the NPC tile wins over any key event on the same clock.
        if ((r_state != StIdle) && (i_current_pix != r_pix)) begin
            w_state_d = StIdle;
            w_npc_d   = r_npc;
            w_page_d  = '0;
            w_flags_d = r_flags;
`ifdef DIALOG_TYPEWRITER_EN
            w_reveal_d = '0;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_npc   <= '0;
            r_pix   <= '0;
            r_page  <= '0;
            r_flags <= '0;
            r_key   <= '0;
            r_key_d <= '0;
`ifdef DIALOG_TYPEWRITER_EN
            r_reveal <= '0;
            r_frm    <= '0;
            r_vblnk  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_npc   <= w_npc_d;
            r_pix   <= w_pix_d;
            r_page  <= w_page_d;
            r_flags <= w_flags_d;
            r_key   <= i_key;
            r_key_d <= r_key;
`ifdef DIALOG_TYPEWRITER_EN
            r_reveal <= w_reveal_d;
            r_frm    <= w_frm_d;
            r_vblnk  <= i_vblnk;
`endif
        end
    end

    assign o_active  = (r_state != StIdle);
    assign o_npc_sel = r_npc;
    assign o_page    = r_page;
    assign o_flags   = r_flags;

    // Overlay pipeline: stage 1 addresses the text/font ROMs, stage 2 waits for the glyph row.
    logic [6:0]  w_dx;
    logic [5:0]  w_dy;
    logic        w_in_box, w_show, w_glyph_bit;
    logic [25:0] w_tim_in, r_tim1, r_tim2, r_tim3;
    logic [11:0] r_rgb1, r_rgb2, r_rgb3;
    logic        r_hit1, r_hit2, r_show1, r_show2;
    logic [2:0]  r_bit1, r_bit2;

    assign w_dx     = 7'(i_hcount - BX);
    assign w_dy     = 6'(i_vcount - BY);
    assign w_in_box = (i_hcount >= BX) && (i_hcount < BX + 11'd128) &&
                      (i_vcount >= BY) && (i_vcount < BY + 11'd64);
    assign w_tim_in = {i_hcount, i_vcount, i_hsync, i_vsync, i_hblnk, i_vblnk};

`ifdef DIALOG_TYPEWRITER_EN
    assign w_show = ({1'b0, w_dy[5:4], w_dx[6:3]} < r_reveal);
`else
    assign w_show = 1'b1;
`endif

    assign w_glyph_bit = i_char_line_pixels[3'd7 - r_bit2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tim1      <= '0;
            r_tim2      <= '0;
            r_tim3      <= '0;
            r_rgb1      <= '0;
            r_rgb2      <= '0;
            r_rgb3      <= '0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_show1     <= 1'b0;
            r_show2     <= 1'b0;
            r_bit1      <= '0;
            r_bit2      <= '0;
            o_char_xy   <= '0;
            o_char_line <= '0;
        end else begin
            r_tim1      <= w_tim_in;
            r_tim2      <= r_tim1;
            r_tim3      <= r_tim2;
            r_rgb1      <= i_rgb;
            r_rgb2      <= r_rgb1;
            r_hit1      <= w_in_box && o_active;
            r_hit2      <= r_hit1;
            r_show1     <= w_show;
            r_show2     <= r_show1;
            r_bit1      <= w_dx[2:0];
            r_bit2      <= r_bit1;
            o_char_xy   <= w_in_box ? {2'b00, w_dy[5:4], w_dx[6:3]} : 8'h00;
            o_char_line <= w_in_box ? w_dy[3:0] : 4'h0;
            if (r_hit2) r_rgb3 <= (w_glyph_bit && r_show2) ? TEXT_COLOR : BG_COLOR;
            else        r_rgb3 <= r_rgb2;
        end
    end

    assign {o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk} = r_tim3;
    assign o_rgb = r_rgb3;

endmodule

// File: tb/tb_game_dialog_ctrl.sv
// Directed bench for game_dialog_ctrl with a registered font/text ROM model.
// Expectations follow the build: DIALOG_TYPEWRITER_EN defined or not.
module tb_game_dialog_ctrl;

    localparam logic [11:0] TXT = 12'hFFF;
    localparam logic [11:0] BG  = 12'hFF0;
    localparam logic [11:0] PIN = 12'h5A5;
`ifdef DIALOG_TYPEWRITER_EN
    localparam int REV0 = 5;
`else
    localparam int REV0 = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0, vcount = '0;
    logic        hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
    logic [11:0] rgb = '0;
    logic [10:0] o_hcount, o_vcount;
    logic        o_hsync, o_vsync, o_hblnk, o_vblnk;
    logic [11:0] o_rgb;
    logic [3:0]  key = '0, cur_pix = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [7:0]  rom_q = '0;
    logic [1:0]  npc_sel;
    logic [1:0]  page;
    logic        active;
    logic [3:0]  flags;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Glyph row one clock after the address: pattern depends on both char and line.
    always @(posedge clk) rom_q <= char_xy ^ {char_line, char_line};

    game_dialog_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_hcount(hcount), .i_vcount(vcount), .i_hsync(hsync), .i_vsync(vsync),
        .i_hblnk(hblnk), .i_vblnk(vblnk), .i_rgb(rgb),
        .o_hcount(o_hcount), .o_vcount(o_vcount), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_hblnk(o_hblnk), .o_vblnk(o_vblnk), .o_rgb(o_rgb),
        .i_key(key), .i_current_pix(cur_pix),
        .o_char_xy(char_xy), .o_char_line(char_line), .i_char_line_pixels(rom_q),
        .o_npc_sel(npc_sel), .o_page(page), .o_active(active), .o_flags(flags)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(logic [3:0] k);
        key = k;
        step(2);
    endtask

    task automatic release_key();
        key = 4'h0;
        step(3);
    endtask

    task automatic skip_type();
`ifdef DIALOG_TYPEWRITER_EN
        press(4'h2);
        release_key();
`endif
    endtask

    task automatic next_page();
        press(4'h2);
        release_key();
        skip_type();
    endtask

    task automatic goto_last();
        skip_type();
        repeat (3) next_page();
    endtask

    function automatic logic [11:0] exp_rgb(int h, int v, bit act, int rev);
        int dx = h - 400;
        int dy = v - 600;
        logic [7:0] g;
        if (!act || dx < 0 || dx >= 128 || dy < 0 || dy >= 64) return PIN;
        g = 8'(((dy / 16) << 4) | (dx / 8)) ^ 8'(((dy % 16) << 4) | (dy % 16));
        if (g[7 - (dx % 8)] && ((dy / 16) * 16 + dx / 8) < rev) return TXT;
        return BG;
    endfunction

    task automatic pix_check(string tag, int h, int v, bit act, int rev);
        hcount = 11'(h);
        vcount = 11'(v);
        rgb    = PIN;
        step(3);
        check(tag, 32'(o_rgb), 32'(exp_rgb(h, v, act, rev)));
    endtask

    initial begin
        // Reset state with busy inputs.
        hsync = 1'b1;
        rgb   = 12'hFFF;
        step(2);
        check("rst_hsync", 32'(o_hsync), 32'd0);
        check("rst_rgb", 32'(o_rgb), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_char_xy", 32'(char_xy), 32'd0);
        hsync = 1'b0;
        rgb   = '0;
        rst_n = 1'b1;
        step(1);

        // Enter dialog with NPC 0.
        cur_pix = 4'h2;
        step(1);
        check("enter_active", 32'(active), 32'd1);
        check("enter_npc", 32'(npc_sel), 32'd0);
        check("enter_page", 32'(page), 32'd0);

        repeat (10) begin
            vblnk = 1'b1;
            step(1);
            vblnk = 1'b0;
            step(1);
        end
        pix_check("char4_text", 437, 600, 1'b1, REV0);
        check("char4_xy", 32'(char_xy), 32'h04);
        pix_check("char5", 445, 600, 1'b1, REV0);
        pix_check("char4_zero_bit", 432, 600, 1'b1, REV0);
        pix_check("outside_box", 100, 100, 1'b1, REV0);
        pix_check("char35", 425, 637, 1'b1, REV0);
        check("char35_xy", 32'(char_xy), 32'h23);
        check("char35_line", 32'(char_line), 32'h5);
        pix_check("char63_pre", 522, 648, 1'b1, REV0);

        skip_type();
        check("wait_page0", 32'(page), 32'd0);
        pix_check("char63_full", 522, 648, 1'b1, 64);
        for (int p = 1; p < 4; p++) begin
            next_page();
            check("page_adv", 32'(page), 32'(p));
        end
        press(4'h2);
        check("last_next_active", 32'(active), 32'd0);
        check("last_next_page", 32'(page), 32'd0);
        check("last_next_flags", 32'(flags), 32'd0);
        release_key();

        // NPC 1 without its prerequisite.
        cur_pix = 4'h3;
        step(2);
        check("npc1_sel", 32'(npc_sel), 32'd1);
        goto_last();
        check("npc1_last_page", 32'(page), 32'd3);
        press(4'h1);
        check("npc1_noprereq_active", 32'(active), 32'd0);
        check("npc1_noprereq_flags", 32'(flags), 32'h0);
        release_key();

        // NPC 0 accept, key held long.
        cur_pix = 4'h2;
        step(2);
        goto_last();
        press(4'h1);
        check("npc0_flag", 32'(flags), 32'h1);
        step(98);
        check("held_flags", 32'(flags), 32'h1);
        check("held_reenter", 32'(active), 32'd1);
        release_key();

        // NPC 1 now has its prerequisite.
        cur_pix = 4'h3;
        step(2);
        goto_last();
        press(4'h1);
        check("npc1_flag", 32'(flags), 32'h3);
        release_key();

        // ACCEPT on a non-last page is ignored.
        skip_type();
        press(4'h1);
        check("accept_p0_active", 32'(active), 32'd1);
        check("accept_p0_page", 32'(page), 32'd0);
        release_key();

        // Walk-away on the same clock as a NEXT event.
        cur_pix = 4'h2;
        step(2);
        next_page();
        check("walk_pre_page", 32'(page), 32'd1);
        key = 4'h2;
        step(1);
        cur_pix = 4'h0;
        step(1);
        check("walk_active", 32'(active), 32'd0);
        check("walk_page", 32'(page), 32'd0);
        check("walk_flags", 32'(flags), 32'h3);
        release_key();
        check("walk_stays_idle", 32'(active), 32'd0);
        pix_check("idle_passthru", 437, 600, 1'b0, 64);

        // Three-clock timing delay.
        hsync = 1'b1;
        step(1);
        hsync = 1'b0;
        step(1);
        check("hsync_d2", 32'(o_hsync), 32'd0);
        step(1);
        check("hsync_d3", 32'(o_hsync), 32'd1);
        step(1);
        check("hsync_d4", 32'(o_hsync), 32'd0);

        // Asynchronous reset mid-dialog.
        cur_pix = 4'h2;
        step(1);
        hsync = 1'b1;
        step(3);
        check("pre_rst_hsync", 32'(o_hsync), 32'd1);
        check("pre_rst_active", 32'(active), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_hsync", 32'(o_hsync), 32'd0);
        check("async_rst_flags", 32'(flags), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("post_rst_hsync_d2", 32'(o_hsync), 32'd0);
        step(1);
        check("post_rst_hsync_d3", 32'(o_hsync), 32'd1);
        check("post_rst_active", 32'(active), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
